cache_mem_responder: RTL

//  Memory-side responder for the cache memory interface. It serves dcache

---
 rtl/cache_mem_responder.sv | 90 +++++++++
 1 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: fixed-latency word RAM shared by dcache and icache, dcache first
module cache_mem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int LAT    = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LAT);
  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-1:0] idx;
  logic [DATA_W-1:0] wdata;
  logic op_w;
  logic [DATA_W-1:0] ram [DEPTH];
  logic d_req, done, d_wr;
  logic unused;
  assign d_req  = dREN | dWEN;
  assign done   = cnt == LAT_C;
  assign d_wr   = state == DBUSY && d_req && done && op_w;
  assign unused = ^{daddr[ADDR_W-1:AW+2], daddr[1:0], iaddr[ADDR_W-1:AW+2], iaddr[1:0]};
  // next state, completion pulses and read data; abort wins when the owner drops its request
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dwait   = 1'b1;
    iwait   = 1'b1;
    dload   = '0;
    iload   = '0;
    unique case (state)
      IDLE: begin
        state_n = d_req ? DBUSY : iREN ? IBUSY : IDLE;
        cnt_n   = (d_req | iREN) ? CW'(1) : cnt;
      end
      DBUSY: begin
        state_n = (!d_req || done) ? IDLE : DBUSY;
        cnt_n   = (!d_req || done) ? '0 : cnt + CW'(1);
        dwait   = !(d_req && done);
        dload   = (d_req && done && !op_w) ? ram[idx] : '0;
      end
      IBUSY: begin
        state_n = (!iREN || done) ? IDLE : IBUSY;
        cnt_n   = (!iREN || done) ? '0 : cnt + CW'(1);
        iwait   = !(iREN && done);
        iload   = (iREN && done) ? ram[idx] : '0;
      end
      default: state_n = IDLE;
    endcase
  end
  // state, counter and request latches captured on accept
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      wdata <= '0;
      op_w  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && d_req) begin
        idx   <= daddr[AW+1:2];
        wdata <= dstore;
        op_w  <= dWEN;
      end else if (state == IDLE && iREN) begin
        idx  <= iaddr[AW+1:2];
        op_w <= 1'b0;
      end
    end
  end
  // write commits at the closing edge of a dcache write completion
  always_ff @(posedge CLK) begin
    if (d_wr) ram[idx] <= wdata;
  end
endmodule
